store_monitor: RTL and testbench
================================

Name: store_monitor

Overview:
- Synthesizable, parametrised self-check monitor on the processor data-memory write port (memwrite, dataadr, writedata).
- Classifies every store as pass, scratch (allowed) or fail, and adds a cycle timeout.
- Keeps sticky pass/fail/timeout verdicts, a store counter and a capture of the last store.
- Usable in simulation next to the top-level core and on FPGA, with verdicts driven to LEDs.

Parameters:
WIDTH, 32, data and address width
PASS_ADDR, 84, store address that ends the test successfully when paired with PASS_DATA
PASS_DATA, 32'hFFFF7F02 (-33022), store data required at PASS_ADDR
SCRATCH_ADDR, 80, address whose stores are legal and non-terminating
TIMEOUT, 1000, cycles in RUN before a TIMEOUT verdict; 0 disables the timeout
CNT_W, 16, width of store_count and the cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
memwrite  in  1  store strobe from the core, one store per cycle when high
dataadr  in  WIDTH  store byte address
writedata  in  WIDTH  store data
pass  out  1  sticky success verdict
fail  out  1  sticky failure verdict
timeout  out  1  sticky timeout verdict
done  out  1  pass | fail | timeout
store_count  out  CNT_W  number of stores classified in RUN, saturating
last_addr  out  WIDTH  address of the most recent classified store
last_data  out  WIDTH  data of the most recent classified store

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Sampling: inputs are sampled on the rising edge of clk. All outputs are registered.
- Latency: a store sampled at edge k is reflected in the outputs immediately after edge k.
- Reset (any state, including mid-run):
  - state <= RUN.
  - pass, fail, timeout, done, store_count, cycle counter, last_addr and last_data all <= 0.
  - Inputs present during a reset cycle are ignored.
- State machine: RUN, PASS, FAIL, TIMEOUT.
  - PASS, FAIL and TIMEOUT are terminal and hold until reset.
  - The pass, fail and timeout outputs are the state decode; at most one is high.
- RUN, memwrite=1, priority order:
  1. dataadr==PASS_ADDR and writedata==PASS_DATA -> PASS.
  2. dataadr==SCRATCH_ADDR (any data) -> stay in RUN.
  3. Otherwise -> FAIL. This includes PASS_ADDR with wrong data.
  - Every classified store, including the terminating one: store_count += 1 (saturates at 2^CNT_W-1); last_addr and last_data are loaded.
- RUN, memwrite=0: no classification; counters and captures hold.
- Timeout:
  - The cycle counter increments on every RUN cycle and saturates.
  - When TIMEOUT!=0 and the counter equals TIMEOUT-1 on an edge with no terminating store -> TIMEOUT.
  - If a store and timeout expiry fall on the same edge, store classification wins, so PASS or FAIL takes precedence.
  - TIMEOUT=0: the counter runs, but the TIMEOUT state is unreachable.
- Terminal states:
  - memwrite is ignored.
  - store_count, last_addr, last_data and the cycle counter freeze.
- Comparisons are full-width and exact; no address masking.
- X or Z on memwrite is not special-cased in RTL. The bench must drive known values.
- Required RTL assertion: pass, fail and timeout are mutually exclusive.

Test Plan:
1. reset high for 2 cycles, then scratch stores {80,7} and {80,0}, then {84,32'hFFFF7F02} -> pass=1 one edge after the final store; store_count=3; last_addr=84; last_data=32'hFFFF7F02; fail=timeout=0; the state holds for 50 further cycles despite a {100,1} store.
2. After reset, store {84,32'h0000_7F02} -> fail=1, done=1, store_count=1, last_data=32'h00007F02; a later {84,32'hFFFF7F02} does not set pass.
3. After reset, store {60,5} -> fail=1, last_addr=60; a following scratch store leaves store_count=1.
4. TIMEOUT=20, no stores after reset -> timeout=1 exactly after the 20th RUN edge; pass=fail=0; store_count=0. Repeat with {84,PASS_DATA} presented on the 20th edge -> pass=1, timeout=0.
5. TIMEOUT=0, idle for 5000 cycles -> done stays 0. Then {84,PASS_DATA} -> pass=1.
6. Reach FAIL, assert reset for one cycle mid-stream with memwrite=1 {84,PASS_DATA} -> all outputs 0 after the reset edge. Next edge with the same store -> pass=1, store_count=1.

Source files
------------

// File: rtl/store_monitor.sv
// store_monitor: self-check monitor on the core's data-memory write port.
// Classifies each store as pass, scratch or fail, adds a cycle timeout and
// keeps sticky verdicts, a saturating store counter and a last-store capture.
module store_monitor #(
   parameter int                WIDTH        = 32,
   parameter logic [WIDTH-1:0]  PASS_ADDR    = 84,
   parameter logic [WIDTH-1:0]  PASS_DATA    = 32'hFFFF7F02,
   parameter logic [WIDTH-1:0]  SCRATCH_ADDR = 80,
   parameter int                TIMEOUT      = 1000,
   parameter int                CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             memwrite,
   input  logic [WIDTH-1:0] dataadr,
   input  logic [WIDTH-1:0] writedata,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic             done,
   output logic [CNT_W-1:0] store_count,
   output logic [WIDTH-1:0] last_addr,
   output logic [WIDTH-1:0] last_data
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PASS = 2'd1,
      ST_FAIL = 2'd2,
      ST_TMO  = 2'd3
   } state_t;

   // Counter value on the last RUN edge before expiry; unused when TIMEOUT is 0.
   localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state, state_next;
   logic             capture;
   logic [CNT_W-1:0] cycle_cnt;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) state <= ST_RUN;
      else       state <= state_next;
   end

   // Next-state decode: store classification first, timeout only if no verdict.
   always_comb begin
      // NOTE: defaults first so every path assigns every output; no latches.
      state_next = state;
      capture    = 1'b0;
      if (state == ST_RUN) begin
         if (memwrite) begin
            capture = 1'b1;
            if (dataadr == PASS_ADDR && writedata == PASS_DATA)
               state_next = ST_PASS;
            else if (dataadr != SCRATCH_ADDR)
               state_next = ST_FAIL;
         end
         if (TIMEOUT != 0 && state_next == ST_RUN && cycle_cnt == TMO_LAST)
            state_next = ST_TMO;
      end
   end

   // Registered verdicts, counters and last-store capture; all frozen outside RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         pass        <= 1'b0;
         fail        <= 1'b0;
         timeout     <= 1'b0;
         done        <= 1'b0;
         store_count <= '0;
         cycle_cnt   <= '0;
         last_addr   <= '0;
         last_data   <= '0;
      end else begin
         pass    <= (state_next == ST_PASS);
         fail    <= (state_next == ST_FAIL);
         timeout <= (state_next == ST_TMO);
         done    <= (state_next != ST_RUN);
         if (state == ST_RUN && cycle_cnt != CNT_MAX)
            cycle_cnt <= cycle_cnt + 1'b1;
         if (capture) begin
            if (store_count != CNT_MAX)
               store_count <= store_count + 1'b1;
            last_addr <= dataadr;
            last_data <= writedata;
         end
      end
   end

   // At most one verdict may ever be asserted.
   verdict_onehot: assert property (@(posedge clk) disable iff (reset)
      $onehot0({pass, fail, timeout}));

endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor: directed stimulus against three store_monitor instances
// (TIMEOUT 1000, 20 and 0) sharing one input bus. A behavioural model pushes
// expected outputs into a scoreboard queue; each is popped after the edge.
module tb_store_monitor;

   localparam logic [31:0] PD = 32'hFFFF7F02;
   localparam int NDUT = 3;

   typedef struct packed {
      logic        pass;
      logic        fail;
      logic        timeout;
      logic        done;
      logic [15:0] count;
      logic [31:0] la;
      logic [31:0] ld;
   } exp_t;

   typedef enum int {M_RUN, M_PASS, M_FAIL, M_TMO} mst_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;

   logic [NDUT-1:0]        pass_v, fail_v, tmo_v, done_v;
   logic [NDUT-1:0][15:0]  cnt_v;
   logic [NDUT-1:0][31:0]  la_v, ld_v;

   int total = 0;
   int bad   = 0;

   exp_t sb_q[$];

   int   tmo_p [NDUT] = '{1000, 20, 0};
   mst_t m_st  [NDUT];
   int   m_cyc [NDUT];
   int   m_cnt [NDUT];
   logic [31:0] m_la [NDUT];
   logic [31:0] m_ld [NDUT];

   always #5 clk = ~clk;

   store_monitor #(.TIMEOUT(1000)) dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .pass(pass_v[0]), .fail(fail_v[0]),
      .timeout(tmo_v[0]), .done(done_v[0]), .store_count(cnt_v[0]),
      .last_addr(la_v[0]), .last_data(ld_v[0]));

   store_monitor #(.TIMEOUT(20)) dut20 (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .pass(pass_v[1]), .fail(fail_v[1]),
      .timeout(tmo_v[1]), .done(done_v[1]), .store_count(cnt_v[1]),
      .last_addr(la_v[1]), .last_data(ld_v[1]));

   store_monitor #(.TIMEOUT(0)) dut0 (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .pass(pass_v[2]), .fail(fail_v[2]),
      .timeout(tmo_v[2]), .done(done_v[2]), .store_count(cnt_v[2]),
      .last_addr(la_v[2]), .last_data(ld_v[2]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model of instance i by one edge with the given inputs.
   task automatic model_step(input int i, input logic rst, input logic mw,
                             input logic [31:0] a, input logic [31:0] d);
      bit term;
      if (rst) begin
         m_st[i] = M_RUN; m_cyc[i] = 0; m_cnt[i] = 0; m_la[i] = '0; m_ld[i] = '0;
      end else if (m_st[i] == M_RUN) begin
         term = 1'b0;
         if (mw) begin
            if (m_cnt[i] < 65535) m_cnt[i]++;
            m_la[i] = a;
            m_ld[i] = d;
            if (a == 32'd84 && d == PD) begin m_st[i] = M_PASS; term = 1'b1; end
            else if (a != 32'd80)       begin m_st[i] = M_FAIL; term = 1'b1; end
         end
         if (!term && tmo_p[i] != 0 && m_cyc[i] == tmo_p[i] - 1) m_st[i] = M_TMO;
         if (m_cyc[i] < 65535) m_cyc[i]++;
      end
   endtask

   // One clock: drive inputs, push model expectations, compare after the edge.
   task automatic cyc(input logic rst, input logic mw,
                      input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      reset = rst; memwrite = mw; dataadr = a; writedata = d;
      for (int i = 0; i < NDUT; i++) begin
         model_step(i, rst, mw, a, d);
         e.pass    = (m_st[i] == M_PASS);
         e.fail    = (m_st[i] == M_FAIL);
         e.timeout = (m_st[i] == M_TMO);
         e.done    = (m_st[i] != M_RUN);
         e.count   = 16'(m_cnt[i]);
         e.la      = m_la[i];
         e.ld      = m_ld[i];
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NDUT; i++) begin
         e = sb_q.pop_front();
         chk($sformatf("sb%0d.pass", i),    64'(pass_v[i]), 64'(e.pass));
         chk($sformatf("sb%0d.fail", i),    64'(fail_v[i]), 64'(e.fail));
         chk($sformatf("sb%0d.timeout", i), 64'(tmo_v[i]),  64'(e.timeout));
         chk($sformatf("sb%0d.done", i),    64'(done_v[i]), 64'(e.done));
         chk($sformatf("sb%0d.count", i),   64'(cnt_v[i]),  64'(e.count));
         chk($sformatf("sb%0d.last_addr", i), 64'(la_v[i]), 64'(e.la));
         chk($sformatf("sb%0d.last_data", i), 64'(ld_v[i]), 64'(e.ld));
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;

      // 1: scratch stores then the pass store; verdict holds afterwards.
      cyc(1'b1, 1'b1, 32'd60, 32'd1);
      cyc(1'b1, 1'b0, 32'd0, 32'd0);
      chk("rst.pass",  64'(pass_v[0]), 64'd0);
      chk("rst.done",  64'(done_v[0]), 64'd0);
      chk("rst.count", 64'(cnt_v[0]),  64'd0);
      chk("rst.la",    64'(la_v[0]),   64'd0);
      cyc(1'b0, 1'b1, 32'd80, 32'd7);
      cyc(1'b0, 1'b1, 32'd80, 32'd0);
      chk("t1.pre_pass", 64'(pass_v[0]), 64'd0);
      chk("t1.scr_cnt",  64'(cnt_v[0]),  64'd2);
      cyc(1'b0, 1'b1, 32'd84, PD);
      chk("t1.pass",  64'(pass_v[0]), 64'd1);
      chk("t1.fail",  64'(fail_v[0]), 64'd0);
      chk("t1.tmo",   64'(tmo_v[0]),  64'd0);
      chk("t1.count", 64'(cnt_v[0]),  64'd3);
      chk("t1.la",    64'(la_v[0]),   64'd84);
      chk("t1.ld",    64'(ld_v[0]),   64'(PD));
      cyc(1'b0, 1'b1, 32'd100, 32'd1);
      idle(49);
      chk("t1.hold_pass",  64'(pass_v[0]), 64'd1);
      chk("t1.hold_fail",  64'(fail_v[0]), 64'd0);
      chk("t1.hold_count", 64'(cnt_v[0]),  64'd3);
      chk("t1.hold_la",    64'(la_v[0]),   64'd84);

      // 2: pass address with wrong data fails; later pass store ignored.
      cyc(1'b1, 1'b0, 32'd0, 32'd0);
      cyc(1'b0, 1'b1, 32'd84, 32'h0000_7F02);
      chk("t2.fail",  64'(fail_v[0]), 64'd1);
      chk("t2.done",  64'(done_v[0]), 64'd1);
      chk("t2.count", 64'(cnt_v[0]),  64'd1);
      chk("t2.ld",    64'(ld_v[0]),   64'h7F02);
      cyc(1'b0, 1'b1, 32'd84, PD);
      chk("t2.no_pass", 64'(pass_v[0]), 64'd0);
      chk("t2.ld_held", 64'(ld_v[0]),   64'h7F02);

      // 3: illegal address fails; scratch store after it is not counted.
      cyc(1'b1, 1'b0, 32'd0, 32'd0);
      cyc(1'b0, 1'b1, 32'd60, 32'd5);
      chk("t3.fail", 64'(fail_v[0]), 64'd1);
      chk("t3.la",   64'(la_v[0]),   64'd60);
      cyc(1'b0, 1'b1, 32'd80, 32'd9);
      chk("t3.count", 64'(cnt_v[0]), 64'd1);

      // 4: TIMEOUT=20 fires exactly on the 20th RUN edge; a pass store there wins.
      cyc(1'b1, 1'b0, 32'd0, 32'd0);
      idle(19);
      chk("t4.tmo_early", 64'(tmo_v[1]), 64'd0);
      idle(1);
      chk("t4.tmo",   64'(tmo_v[1]),  64'd1);
      chk("t4.pass",  64'(pass_v[1]), 64'd0);
      chk("t4.fail",  64'(fail_v[1]), 64'd0);
      chk("t4.count", 64'(cnt_v[1]),  64'd0);
      cyc(1'b1, 1'b0, 32'd0, 32'd0);
      idle(19);
      cyc(1'b0, 1'b1, 32'd84, PD);
      chk("t4.race_pass", 64'(pass_v[1]), 64'd1);
      chk("t4.race_tmo",  64'(tmo_v[1]),  64'd0);

      // 5: TIMEOUT=0 never times out; pass still works afterwards.
      cyc(1'b1, 1'b0, 32'd0, 32'd0);
      idle(5000);
      chk("t5.done0", 64'(done_v[2]), 64'd0);
      chk("t5.tmo1k", 64'(tmo_v[0]),  64'd1);
      cyc(1'b0, 1'b1, 32'd84, PD);
      chk("t5.pass", 64'(pass_v[2]), 64'd1);

      // 6: reset mid-stream with a pass store present is ignored, then next edge passes.
      cyc(1'b1, 1'b0, 32'd0, 32'd0);
      cyc(1'b0, 1'b1, 32'd60, 32'd5);
      chk("t6.fail", 64'(fail_v[0]), 64'd1);
      cyc(1'b1, 1'b1, 32'd84, PD);
      chk("t6.rst_fail",  64'(fail_v[0]), 64'd0);
      chk("t6.rst_pass",  64'(pass_v[0]), 64'd0);
      chk("t6.rst_count", 64'(cnt_v[0]),  64'd0);
      chk("t6.rst_ld",    64'(ld_v[0]),   64'd0);
      cyc(1'b0, 1'b1, 32'd84, PD);
      chk("t6.pass",  64'(pass_v[0]), 64'd1);
      chk("t6.count", 64'(cnt_v[0]),  64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
